// File: rtl/chol_div_seq.sv
// chol_div_seq: handshaked, fixed-latency signed fixed-point divider.
//
// Computes quotient = (dividend << FRAC) / divisor on two's-complement
// Q(WIDTH-FRAC).FRAC operands with an iterative restoring core. One quotient bit is
// produced per enabled clock, so latency is data-independent.
//
// Optional feature macro: CHOL_DIV_ROUND_EN
//   defined   - one extra quotient bit is computed and used to round the magnitude
//               half away from zero before the saturation check.
//   undefined - the result truncates toward zero.
//
// Ports:
//   clk, rst   - rising-edge clock, synchronous active-high reset (overrides clken)
//   clken      - clock enable; all state and outputs freeze while low
//   in_valid   - operands valid; in_ready is high only while idle
//   dividend   - signed Q(WIDTH-FRAC).FRAC numerator
//   divisor    - signed Q(WIDTH-FRAC).FRAC denominator
//   out_valid  - result valid, held until out_ready
//   out_ready  - downstream accepts the result
//   quotient   - signed Q(WIDTH-FRAC).FRAC result (symmetric saturation)
//   div_zero   - divisor was zero
//   overflow   - result saturated (never set together with div_zero)

module chol_div_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FRAC  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clken,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic             div_zero,
    output logic             overflow
);

`ifdef CHOL_DIV_ROUND_EN
    localparam int unsigned NumIter = WIDTH + FRAC + 1;
`else
    localparam int unsigned NumIter = WIDTH + FRAC;
`endif
    // Zero bits appended below |dividend| to form the numerator.
    localparam int unsigned Pad    = NumIter - WIDTH;
    localparam int unsigned CntW   = $clog2(NumIter);
    localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFinal, StDone} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]    cnt_q;
    logic [NumIter-1:0] num_q;     // numerator, consumed MSB first
    logic [NumIter-1:0] q_q;       // quotient bits, shifted in LSB first
    logic [WIDTH:0]     rem_q;
    logic [WIDTH-1:0]   dvs_q;     // |divisor|
    logic               sign_q;
    logic               zero_q;    // divisor == 0, held until the result is published

    logic [WIDTH-1:0]   quotient_q;
    logic               div_zero_q;
    logic               overflow_q;

    logic [WIDTH-1:0]   abs_dvd;
    logic [WIDTH-1:0]   abs_dvs;
    logic [WIDTH+1:0]   trial_in;
    logic [WIDTH+1:0]   trial;
    logic               trial_neg;
    logic               last_iter;

    logic [NumIter-1:0] q_mag;
    logic [WIDTH-1:0]   result;
    logic               result_ovf;

    // Negating -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign abs_dvd = dividend[WIDTH-1] ? -dividend : dividend;
    assign abs_dvs = divisor[WIDTH-1]  ? -divisor  : divisor;

    assign trial_in  = {rem_q, num_q[NumIter-1]};
    assign trial     = trial_in - {2'b00, dvs_q};
    assign trial_neg = trial[WIDTH+1];
    assign last_iter = (cnt_q == CntW'(NumIter - 1));

    // ---------------------------------------------------------------- FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else if (clken) begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)  state_d = StCalc;
            StCalc:  if (last_iter) state_d = StFinal;
            StFinal: state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- FSM outputs
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
    end

    // ---------------------------------------------------------------- result selection
    always_comb begin
`ifdef CHOL_DIV_ROUND_EN
        // LSB of q_q is the half bit; adding it rounds half away from zero.
        q_mag = {1'b0, q_q[NumIter-1:1]} + {{(NumIter-1){1'b0}}, q_q[0]};
`else
        q_mag = q_q;
`endif
        result_ovf = 1'b0;
        if (zero_q) begin
            // Divisor sign bit is 0 here, so sign_q is the dividend's sign.
            result = sign_q ? -MaxPos : MaxPos;
        end else if (q_mag > {{Pad{1'b0}}, MaxPos}) begin
            result_ovf = 1'b1;
            result     = sign_q ? -MaxPos : MaxPos;
        end else begin
            result = sign_q ? -q_mag[WIDTH-1:0] : q_mag[WIDTH-1:0];
        end
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            num_q      <= '0;
            q_q        <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            sign_q     <= 1'b0;
            zero_q     <= 1'b0;
            quotient_q <= '0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
        end else if (clken) begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        num_q  <= {abs_dvd, {Pad{1'b0}}};
                        dvs_q  <= abs_dvs;
                        zero_q <= (divisor == '0);
                        rem_q  <= '0;
                        q_q    <= '0;
                        cnt_q  <= '0;
                    end
                end
                StCalc: begin
                    num_q <= num_q << 1;
                    rem_q <= trial_neg ? trial_in[WIDTH:0] : trial[WIDTH:0];
                    q_q   <= {q_q[NumIter-2:0], ~trial_neg};
                    cnt_q <= cnt_q + 1'b1;
                end
                StFinal: begin
                    quotient_q <= result;
                    div_zero_q <= zero_q;
                    overflow_q <= result_ovf;
                end
                default: ;
            endcase
        end
    end

    assign quotient = quotient_q;
    assign div_zero = div_zero_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_chol_div_seq.sv
// Self-checking bench for chol_div_seq (WIDTH=32, FRAC=16). A plain-arithmetic model
// produces the expected quotient/flags; a negedge monitor compares every cycle that
// out_valid is high. Honours CHOL_DIV_ROUND_EN the same way the design does.

module tb_chol_div_seq;

    localparam int unsigned W = 32;
    localparam int unsigned F = 16;
`ifdef CHOL_DIV_ROUND_EN
    localparam int Lat      = W + F + 2;
    localparam bit RoundEn  = 1'b1;
`else
    localparam int Lat      = W + F + 1;
    localparam bit RoundEn  = 1'b0;
`endif
    localparam logic [31:0] MaxPos = 32'h7FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clken = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] quotient;
    logic        div_zero;
    logic        overflow;

    chol_div_seq #(
        .WIDTH (W),
        .FRAC  (F)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clken     (clken),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    int          en_mode = 0;   // 0: always enabled, 1: 50% toggle, 2: random
    bit          last_en = 1'b0;
    bit          exp_set = 1'b0;
    logic [31:0] exp_q   = '0;
    logic        exp_dz  = 1'b0;
    logic        exp_ov  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer division of |a|*2^F by |b|, then sign and saturation.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic dz, output logic ov);
        longint          sa;
        longint          sb;
        longint unsigned ma;
        longint unsigned mb;
        longint unsigned num;
        longint unsigned mag;
        bit              neg;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ma  = (sa < 0) ? longint'(-sa) : longint'(sa);
        mb  = (sb < 0) ? longint'(-sb) : longint'(sb);
        neg = (sa < 0) ^ (sb < 0);
        num = ma << F;
        dz  = 1'b0;
        ov  = 1'b0;
        if (mb == 0) begin
            dz = 1'b1;
            q  = (sa < 0) ? -MaxPos : MaxPos;
        end else begin
            if (RoundEn) mag = (2 * num + mb) / (2 * mb);
            else         mag = num / mb;
            if (mag > 64'(MaxPos)) begin
                ov  = 1'b1;
                mag = 64'(MaxPos);
            end
            q = neg ? 32'(-mag) : 32'(mag);
        end
    endfunction

    function automatic logic pick_en();
        case (en_mode)
            1:       return ~clken;
            2:       return 1'($urandom_range(0, 1));
            default: return 1'b1;
        endcase
    endfunction

    // Advance one clock: record whether the rising edge was enabled, then set up the next.
    task automatic step();
        @(posedge clk);
        last_en = clken;
        @(negedge clk);
        clken = pick_en();
    endtask

    // Every cycle the result is presented it must match the model and in_ready must be low.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (!exp_set) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("quotient", quotient, exp_q);
                check("div_zero", 32'(div_zero), 32'(exp_dz));
                check("overflow", 32'(overflow), 32'(exp_ov));
                check("in_ready_in_done", 32'(in_ready), 32'd0);
            end
        end
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] q;
        logic        dz;
        logic        ov;
        int          edges;
        int          steps;
        model(a, b, q, dz, ov);
        exp_q   = q;
        exp_dz  = dz;
        exp_ov  = ov;
        exp_set = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        steps = 0;
        do begin
            step();
            steps++;
        end while (!last_en && steps < 100);
        // In flight: garbage on the inputs and out_ready must be ignored.
        edges = 0;
        while (!out_valid && steps < 2000) begin
            in_valid  = 1'($urandom_range(0, 1));
            dividend  = $urandom;
            divisor   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            step();
            steps++;
            if (last_en) edges++;
        end
        out_ready = 1'b0;
        check("latency_enabled_edges", 32'(edges), 32'(Lat));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            dividend = $urandom;
            divisor  = $urandom;
            step();
            check("in_ready_while_held", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        steps = 0;
        do begin
            step();
            steps++;
        end while (!last_en && steps < 100);
        out_ready = 1'b0;
        check("in_ready_after_accept", 32'(in_ready), 32'd1);
        check("out_valid_after_accept", 32'(out_valid), 32'd0);
    endtask

    // Pin the model to a hand-computed value, then run the vector through the DUT.
    task automatic pinned(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit_q, input logic lit_dz, input logic lit_ov);
        logic [31:0] q;
        logic        dz;
        logic        ov;
        model(a, b, q, dz, ov);
        check({name, "_model_q"}, q, lit_q);
        check({name, "_model_flags"}, {30'd0, dz, ov}, {30'd0, lit_dz, lit_ov});
        do_op(a, b, 2);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_quotient"}, quotient, 32'd0);
        check({tag, "_div_zero"}, 32'(div_zero), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        // Reset with clken low: reset must still take effect.
        rst   = 1'b1;
        clken = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        clken = 1'b1;
        check_reset_values("reset");

        en_mode = 0;
        pinned("div_6_by_2", 32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 1'b0, 1'b0);
        pinned("div_2_by_3", 32'h0002_0000, 32'h0003_0000,
               RoundEn ? 32'h0000_AAAB : 32'h0000_AAAA, 1'b0, 1'b0);
        pinned("div_1_by_3", 32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0);
        pinned("neg_dividend", 32'hFFF8_8000, 32'h0002_0000, 32'hFFFC_4000, 1'b0, 1'b0);
        pinned("neg_divisor", 32'h0003_0000, 32'hFFFF_0000, 32'hFFFD_0000, 1'b0, 1'b0);
        pinned("pos_by_zero", 32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
        pinned("neg_by_zero", 32'hFFFF_0000, 32'h0000_0000, 32'h8000_0001, 1'b1, 1'b0);
        pinned("overflow", 32'h4000_0000, 32'h0000_8000, 32'h7FFF_FFFF, 1'b0, 1'b1);
        pinned("most_neg", 32'h8000_0000, 32'h0001_0000, 32'h8000_0001, 1'b0, 1'b1);

        // Same basic divide with clken toggling at 50% and a long DONE hold.
        en_mode = 1;
        do_op(32'h0006_0000, 32'h0002_0000, 10);
        en_mode = 2;
        do_op(32'h0002_0000, 32'h0003_0000, 10);

        // Randomised operands across magnitude classes and enable patterns.
        for (int i = 0; i < 36; i++) begin
            en_mode = i % 3;
            sel = $urandom_range(0, 5);
            a = $urandom;
            b = $urandom;
            case (sel)
                1: begin
                    a = $urandom_range(0, 32'h00FF_FFFF);
                    b = $urandom_range(1, 32'h0003_FFFF);
                    if ($urandom_range(0, 1) == 1) a = -a;
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                2: b = 32'h0;
                3: a = 32'h8000_0000;
                4: b = 32'h8000_0000 | ($urandom & 32'h7000_0000);
                5: begin
                    a = $urandom_range(0, 32'h0000_FFFF);
                    b = $urandom_range(1, 32'h0000_00FF);
                end
                default: ;
            endcase
            do_op(a, b, $urandom_range(0, 5));
        end

        // Reset mid-calculation discards the operation.
        en_mode  = 0;
        dividend = 32'h0006_0000;
        divisor  = 32'h0002_0000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        check("busy_before_reset", 32'(in_ready), 32'd0);
        exp_set = 1'b0;
        rst     = 1'b1;
        clken   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        clken = 1'b1;
        check_reset_values("mid_calc_reset");
        repeat (Lat + 20) step();
        check("idle_after_reset", 32'(in_ready), 32'd1);

        // The block is usable again after the aborted operation.
        do_op(32'hFFF8_8000, 32'h0002_0000, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
